bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_pkg.sv | 27 ++
 rtl/bin_to_bcd_seq_digit_cell.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Smallest digit count d such that 10^d > 2^width.
  function automatic int min_digits(input int width);
    longint unsigned limit;
    longint unsigned pow10;
    int              d;
    limit = 64'd1 << width;
    pow10 = 64'd1;
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= limit) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_cell.sv
// One double-dabble digit slice: add-3 correction followed by a one-bit left shift.
module bcd_digit_cell (
  input  logic [3:0] digit_in,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  logic [3:0] adj;

  // Correct digits >= 5 so the following shift carries into the next decade.
  always_comb begin
    adj       = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
    digit_out = {adj[2:0], carry_in};
    carry_out = adj[3];
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional signed input.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be within 4..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH");
  end

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic                  neg_q, neg_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  done_q, done_d;

  logic [DIGITS:0]       carry;
  logic [4*DIGITS-1:0]   shifted;

  // The magnitude MSB feeds the units digit; each decade carries into the next.
  assign carry[0] = mag_q[WIDTH-1];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit_in  (work_q[4*k +: 4]),
      .carry_in  (carry[k]),
      .digit_out (shifted[4*k +: 4]),
      .carry_out (carry[k+1])
    );
  end

  // State and datapath registers; reset clears everything, including a conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath control: latch in IDLE, shift WIDTH times, publish in DONE.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Magnitude register is unsigned, so negating the most negative value is exact.
          if (signed_mode && bin_in[WIDTH-1]) begin
            mag_d  = -bin_in;
            sign_d = 1'b1;
          end else begin
            mag_d  = bin_in;
            sign_d = 1'b0;
          end
          work_d  = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        mag_d  = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = work_q;
        neg_d   = sign_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With a legal DIGITS the top decade never reaches 5 before a shift, so nothing falls off.
  always @(posedge clk) begin
    if (!rst && state_q == SHIFT) begin
      assert (!carry[DIGITS]);
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign negative = neg_q;
  assign bcd_out  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and exhaustive checks for bin_to_bcd_seq at WIDTH=8 and WIDTH=16.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  bin_in = 8'h00;
  logic        busy, done, negative;
  logic [11:0] bcd_out;

  logic        start16 = 1'b0;
  logic        sm16 = 1'b0;
  logic [15:0] bin16 = 16'h0000;
  logic        busy16, done16, neg16;
  logic [19:0] bcd16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .bin_in(bin_in),
    .busy(busy), .done(done), .negative(negative), .bcd_out(bcd_out)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .bin_in(bin16),
    .busy(busy16), .done(done16), .negative(neg16), .bcd_out(bcd16)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one 8-bit conversion, scramble the inputs after the start edge, wait for done.
  task automatic do_conv(input logic sm, input logic [7:0] v,
                         output logic [11:0] bcd, output logic neg, output int lat);
    start = 1'b1; signed_mode = sm; bin_in = v;
    tick();
    start = 1'b0; bin_in = ~v; signed_mode = ~sm;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    bcd = bcd_out;
    neg = negative;
  endtask

  task automatic do_conv16(input logic sm, input logic [15:0] v,
                           output logic [19:0] bcd, output logic neg, output int lat);
    start16 = 1'b1; sm16 = sm; bin16 = v;
    tick();
    start16 = 1'b0; bin16 = ~v; sm16 = ~sm;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done16 === 1'b1) begin
        lat = i;
        break;
      end
    end
    bcd = bcd16;
    neg = neg16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy, done, negative, bcd_out} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b neg=%b bcd=%h, want all zero", busy, done, negative, bcd_out);
    end
    n_checks++;
    if ({busy16, done16, neg16, bcd16} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs16: got busy=%b done=%b neg=%b bcd=%h, want all zero", busy16, done16, neg16, bcd16);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_max();
    int lat = -1;
    int busy_cycles = 0;
    start = 1'b1; signed_mode = 1'b0; bin_in = 8'hFF;
    tick();
    start = 1'b0; bin_in = 8'h00; signed_mode = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b, want 1", busy);
    end
    if (busy === 1'b1) busy_cycles++;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL latency_ff: got %0d cycles, want 9", lat);
    end
    n_checks++;
    if (bcd_out !== 12'h255 || negative !== 1'b0) begin
      n_fail++;
      $display("FAIL unsigned_ff: got bcd=%h neg=%b, want 255 neg=0", bcd_out, negative);
    end
    n_checks++;
    if (busy_cycles != 9) begin
      n_fail++;
      $display("FAIL busy_span: got %0d busy cycles, want 9", busy_cycles);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_done: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_signed();
    logic [11:0] b;
    logic        n;
    int          lat;
    do_conv(1'b1, 8'h80, b, n, lat);
    n_checks++;
    if (lat != 9 || b !== 12'h128 || n !== 1'b1) begin
      n_fail++;
      $display("FAIL signed_80: got bcd=%h neg=%b lat=%0d, want 128 neg=1 lat=9", b, n, lat);
    end
    do_conv(1'b1, 8'hF6, b, n, lat);
    n_checks++;
    if (b !== 12'h010 || n !== 1'b1) begin
      n_fail++;
      $display("FAIL signed_f6: got bcd=%h neg=%b, want 010 neg=1", b, n);
    end
    do_conv(1'b1, 8'h7F, b, n, lat);
    n_checks++;
    if (b !== 12'h127 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_7f: got bcd=%h neg=%b, want 127 neg=0", b, n);
    end
    do_conv(1'b0, 8'h80, b, n, lat);
    n_checks++;
    if (b !== 12'h128 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL unsigned_80: got bcd=%h neg=%b, want 128 neg=0", b, n);
    end
  endtask

  task automatic test_zero();
    logic [11:0] b;
    logic        n;
    int          lat;
    do_conv(1'b1, 8'hFF, b, n, lat);
    do_conv(1'b0, 8'h00, b, n, lat);
    n_checks++;
    if (b !== 12'h000 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_unsigned: got bcd=%h neg=%b, want 000 neg=0", b, n);
    end
    do_conv(1'b1, 8'hFF, b, n, lat);
    do_conv(1'b1, 8'h00, b, n, lat);
    n_checks++;
    if (b !== 12'h000 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_signed: got bcd=%h neg=%b, want 000 neg=0", b, n);
    end
  endtask

  task automatic test_hold();
    logic [11:0] b;
    logic        n;
    int          lat;
    int          changed = 0;
    do_conv(1'b1, 8'h9C, b, n, lat);
    for (int i = 0; i < 6; i++) begin
      bin_in = 8'(i * 37);
      signed_mode = i[0];
      tick();
      if (bcd_out !== 12'h100 || negative !== 1'b1 || done !== 1'b0) changed++;
    end
    n_checks++;
    if (b !== 12'h100 || n !== 1'b1 || changed != 0) begin
      n_fail++;
      $display("FAIL hold_result: got bcd=%h neg=%b changes=%0d, want 100 neg=1 changes=0", b, n, changed);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int last = -1;
    int bad_gap = 0;
    int bad_val = 0;
    start = 1'b1; signed_mode = 1'b0; bin_in = 8'h7F;
    tick();
    for (int i = 1; i < 40; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (bcd_out !== 12'h127 || negative !== 1'b0) bad_val++;
        if (last < 0 && i != 9) bad_gap++;
        if (last >= 0 && (i - last) != 10) bad_gap++;
        last = i;
      end
    end
    start = 1'b0;
    tick(); tick();
    n_checks++;
    if (ndone != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, want 4", ndone);
    end
    n_checks++;
    if (bad_gap != 0 || bad_val != 0) begin
      n_fail++;
      $display("FAIL b2b_timing: got bad_gaps=%0d bad_values=%0d, want 0 0", bad_gap, bad_val);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] b;
    logic        n;
    int          lat;
    int          spurious = 0;
    do_conv(1'b1, 8'hF6, b, n, lat);
    n_checks++;
    if (b !== 12'h010 || n !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_result: got bcd=%h neg=%b, want 010 neg=1", b, n);
    end
    start = 1'b1; signed_mode = 1'b0; bin_in = 8'hFF;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_mid_shift: got %b, want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, negative, bcd_out} !== 15'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b neg=%b bcd=%h, want all zero", busy, done, negative, bcd_out);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d active cycles, want 0", spurious);
    end
    do_conv(1'b0, 8'd42, b, n, lat);
    n_checks++;
    if (lat != 9 || b !== 12'h042 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_42: got bcd=%h neg=%b lat=%0d, want 042 neg=0 lat=9", b, n, lat);
    end
  endtask

  task automatic test_width16();
    logic [19:0] b;
    logic        n;
    int          lat;
    do_conv16(1'b0, 16'hFFFF, b, n, lat);
    n_checks++;
    if (lat != 17 || b !== 20'h65535 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL w16_ffff: got bcd=%h neg=%b lat=%0d, want 65535 neg=0 lat=17", b, n, lat);
    end
    do_conv16(1'b1, 16'h8000, b, n, lat);
    n_checks++;
    if (b !== 20'h32768 || n !== 1'b1) begin
      n_fail++;
      $display("FAIL w16_8000: got bcd=%h neg=%b, want 32768 neg=1", b, n);
    end
  endtask

  task automatic test_exhaustive();
    logic [11:0] b, exp_b;
    logic        n, exp_n;
    int          lat, mag;
    logic [7:0]  v;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 256; x++) begin
        v = 8'(x);
        exp_n = (m == 1) && v[7];
        mag = exp_n ? (256 - x) : x;
        exp_b = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
        do_conv(m[0], v, b, n, lat);
        n_checks++;
        if (lat != 9 || b !== exp_b || n !== exp_n) begin
          n_fail++;
          $display("FAIL sweep mode=%0d in=%h: got bcd=%h neg=%b lat=%0d, want %h neg=%b lat=9",
                   m, v, b, n, lat, exp_b, exp_n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_width16();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
